// File: rtl/puzzle3_stream_ctrl.sv
// rtl/puzzle3_stream_ctrl.sv - ASCII byte stream sequencer for the day-3 max-pair joltage datapath
module puzzle3_stream_ctrl #(
    parameter int SUM_W        = 32,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    input  logic             in_last,
    output logic             dp_clear,
    output logic [3:0]       dp_data,
    output logic             dp_wr_en,
    output logic             dp_bank_end,
    input  logic [SUM_W-1:0] dp_sum,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] result,
    output logic [CNT_W-1:0] bank_count,
    output logic [CNT_W-1:0] digit_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] drain_cnt;
    logic          drain_last;

    logic [3:0]    hold_val;
    logic          hold_vld;

    logic          start_run;
    logic          accept;
    logic          is_digit;
    logic          is_sep;
    logic          emit;
    logic          emit_end;

    assign is_digit   = (in_char >= 8'h30) && (in_char <= 8'h39);
    assign is_sep     = (in_char == 8'h0A) || (in_char == 8'h0D);
    assign drain_last = (drain_cnt == DW'(DRAIN_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        dp_clear  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        start_run = 1'b0;
        accept    = 1'b0;
        emit      = 1'b0;
        emit_end  = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_run = 1'b1;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                dp_clear  = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                in_ready = 1'b1;
                accept   = in_valid;
                // The held digit goes out once the next byte tells us whether it ends its bank.
                if (accept && hold_vld && (is_digit || is_sep)) begin
                    emit     = 1'b1;
                    emit_end = is_sep;
                end
                if (accept && in_last) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                emit      = hold_vld;
                emit_end  = hold_vld;
                state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) begin
                    start_run = 1'b1;
                    state_nxt = S_CLEAR;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_data     <= 4'd0;
            dp_wr_en    <= 1'b0;
            dp_bank_end <= 1'b0;
            hold_val    <= 4'd0;
            hold_vld    <= 1'b0;
            drain_cnt   <= '0;
            result      <= '0;
            bank_count  <= '0;
            digit_count <= '0;
            err_count   <= '0;
        end else begin
            dp_wr_en    <= emit;
            dp_bank_end <= emit_end;
            dp_data     <= emit ? hold_val : 4'd0;

            if (start_run) begin
                hold_val    <= 4'd0;
                hold_vld    <= 1'b0;
                result      <= '0;
                bank_count  <= '0;
                digit_count <= '0;
                err_count   <= '0;
            end

            if (accept) begin
                if (is_digit) begin
                    hold_val <= in_char[3:0];
                    hold_vld <= 1'b1;
                end else if (is_sep) begin
                    hold_vld <= 1'b0;
                end else if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                // A final byte that is a digit stays held for the FLUSH cycle.
            end

            if (state == S_FLUSH) begin
                hold_vld <= 1'b0;
            end

            if (emit && (digit_count != '1)) begin
                digit_count <= digit_count + 1'b1;
            end
            if (emit_end && (bank_count != '1)) begin
                bank_count <= bank_count + 1'b1;
            end

            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
                if (drain_last) begin
                    result <= dp_sum;
                end
            end else begin
                drain_cnt <= '0;
            end
        end
    end

endmodule
